// File: rtl/controlador_dma_memoria.sv
// Bus-master copy engine: moves a block of 32-bit words from a source region to a
// destination region through the data-memory port, one read/capture/write triplet per word.
module controlador_dma_memoria #(
  parameter int unsigned N  = 31,
  parameter int unsigned LW = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inicio,
  input  logic [N:0]    dir_origen,
  input  logic [N:0]    dir_destino,
  input  logic [LW-1:0] longitud,
  output logic          ocupado,
  output logic          hecho,
  output logic          solicitud_bus,
  input  logic          concesion_bus,
  output logic [N:0]    direccion,
  output logic [31:0]   dato_entrada,
  input  logic [31:0]   dato_salida,
  output logic          escritura,
  output logic          lectura
);

  localparam logic [2:0] REPOSO    = 3'd0;
  localparam logic [2:0] SOLICITAR = 3'd1;
  localparam logic [2:0] LEER      = 3'd2;
  localparam logic [2:0] CAPTURA   = 3'd3;
  localparam logic [2:0] ESCRIBIR  = 3'd4;
  localparam logic [2:0] FIN       = 3'd5;

  logic [2:0]    estado_q, estado_d;
  logic [N:0]    origen_q, origen_d;
  logic [N:0]    destino_q, destino_d;
  logic [LW-1:0] long_q, long_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic [N:0]    cnt_ext;

  assign cnt_ext = (N+1)'(cnt_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= REPOSO;
      origen_q  <= '0;
      destino_q <= '0;
      long_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      origen_q  <= origen_d;
      destino_q <= destino_d;
      long_q    <= long_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    origen_d  = origen_q;
    destino_d = destino_q;
    long_d    = long_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          origen_d  = dir_origen;
          destino_d = dir_destino;
          long_d    = longitud;
          cnt_d     = '0;
          estado_d  = (longitud == '0) ? FIN : SOLICITAR;
        end
      end
      SOLICITAR: begin
        if (concesion_bus) estado_d = LEER;
      end
      LEER:    estado_d = CAPTURA;
      CAPTURA: begin
        buf_d    = dato_salida;
        estado_d = ESCRIBIR;
      end
      ESCRIBIR: begin
        // Grant is only re-examined here, so a word is never split by preemption.
        cnt_d = cnt_q + LW'(1);
        if (cnt_d == long_q)    estado_d = FIN;
        else if (concesion_bus) estado_d = LEER;
        else                    estado_d = SOLICITAR;
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // All outputs decode from registered state only; nothing combinational from inputs.
  always_comb begin
    direccion    = '0;
    dato_entrada = '0;
    lectura      = 1'b0;
    escritura    = 1'b0;
    case (estado_q)
      LEER: begin
        direccion = origen_q + cnt_ext;
        lectura   = 1'b1;
      end
      ESCRIBIR: begin
        direccion    = destino_q + cnt_ext;
        dato_entrada = buf_q;
        escritura    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ocupado       = (estado_q != REPOSO);
  assign hecho         = (estado_q == FIN);
  assign solicitud_bus = (estado_q == SOLICITAR) || (estado_q == LEER) ||
                         (estado_q == CAPTURA) || (estado_q == ESCRIBIR);

endmodule

// File: tb/tb_controlador_dma_memoria.sv
// Directed bench for controlador_dma_memoria: a small RAM model, a table of copy jobs with
// expected completion cycles, and a hand-written reset-abort sequence.
module tb_controlador_dma_memoria;

  logic        clk;
  logic        reset_n;
  logic        inicio;
  logic [31:0] dir_origen;
  logic [31:0] dir_destino;
  logic [10:0] longitud;
  logic        ocupado;
  logic        hecho;
  logic        solicitud_bus;
  logic        concesion_bus;
  logic [31:0] direccion;
  logic [31:0] dato_entrada;
  logic [31:0] dato_salida;
  logic        escritura;
  logic        lectura;

  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  controlador_dma_memoria #(.N(31), .LW(11)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inicio        (inicio),
    .dir_origen    (dir_origen),
    .dir_destino   (dir_destino),
    .longitud      (longitud),
    .ocupado       (ocupado),
    .hecho         (hecho),
    .solicitud_bus (solicitud_bus),
    .concesion_bus (concesion_bus),
    .direccion     (direccion),
    .dato_entrada  (dato_entrada),
    .dato_salida   (dato_salida),
    .escritura     (escritura),
    .lectura       (lectura)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read on posedge, write on negedge.
  always @(posedge clk) if (lectura) dato_salida <= mem[direccion[7:0]];
  always @(negedge clk) if (escritura) mem[direccion[7:0]] <= dato_entrada;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [10:0] len;
    int          gs;      // first cycle with grant low
    int          ge;      // first cycle with grant high again
    int          glitch;  // cycle with a spurious inicio (0 = none)
    int          exp_c;   // cycle in which hecho must be high
  } vec_t;

  vec_t vecs [0:5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] expw [0:15];
    logic [31:0] after_w;
    int first_h = 0;
    int pulses = 0;
    int busy_bad = 0;
    int idle_bad = 0;
    int ovl = 0;
    int bus_act = 0;
    for (int k = 0; k < int'(v.len); k++) expw[k] = mem[8'(v.src + 32'(k))];
    after_w = mem[8'(v.dst + 32'(v.len))];
    @(posedge clk); #1;
    dir_origen    = v.src;
    dir_destino   = v.dst;
    longitud      = v.len;
    inicio        = 1'b1;
    concesion_bus = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    for (int c = 1; c <= v.exp_c + 2; c++) begin
      if (hecho) begin
        pulses++;
        if (first_h == 0) first_h = c;
      end
      if (c <= v.exp_c && !ocupado) busy_bad++;
      if (c > v.exp_c && ocupado) idle_bad++;
      if (lectura && escritura) ovl++;
      if (!lectura && !escritura && (direccion != 0 || dato_entrada != 0)) ovl++;
      if (lectura || escritura || solicitud_bus) bus_act++;
      concesion_bus = !(c >= v.gs && c < v.ge);
      inicio = (v.glitch != 0 && c == v.glitch);
      if (v.glitch != 0 && c == v.glitch) begin
        dir_origen  = 32'd120;
        dir_destino = 32'd130;
        longitud    = 11'd1;
      end
      @(posedge clk); #1;
    end
    inicio        = 1'b0;
    concesion_bus = 1'b1;
    check($sformatf("v%0d hecho_cycle", idx), first_h, v.exp_c);
    check($sformatf("v%0d hecho_pulses", idx), pulses, 1);
    check($sformatf("v%0d ocupado_gap", idx), busy_bad, 0);
    check($sformatf("v%0d ocupado_after", idx), idle_bad, 0);
    check($sformatf("v%0d bus_exclusive", idx), ovl, 0);
    if (v.len == 0) check($sformatf("v%0d no_bus_activity", idx), bus_act, 0);
    for (int k = 0; k < int'(v.len); k++)
      check($sformatf("v%0d dst_word%0d", idx, k), mem[8'(v.dst + 32'(k))], expw[k]);
    check($sformatf("v%0d dst_after_untouched", idx), mem[8'(v.dst + 32'(v.len))], after_w);
  endtask

  initial begin
    logic [31:0] rexp [0:3];
    int h_seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[16] = 32'hA0; mem[17] = 32'hA1; mem[18] = 32'hA2; mem[19] = 32'hA3;

    vecs[0] = '{32'd16, 32'd100, 11'd4, 0, 0, 0, 14};         // basic, grant held
    vecs[1] = '{32'd5, 32'd9, 11'd0, 0, 0, 0, 1};             // zero length
    vecs[2] = '{32'd32, 32'd40, 11'd2, 1, 6, 0, 13};          // grant withheld 5 cycles
    vecs[3] = '{32'd48, 32'd60, 11'd3, 7, 10, 0, 14};         // grant drop during word 1
    vecs[4] = '{32'd70, 32'd80, 11'd3, 0, 0, 4, 11};          // spurious inicio mid-copy
    vecs[5] = '{32'hFFFF_FFFE, 32'd200, 11'd3, 0, 0, 0, 11};  // source address wraps

    reset_n       = 1'b0;
    inicio        = 1'b0;
    dir_origen    = '0;
    dir_destino   = '0;
    longitud      = '0;
    concesion_bus = 1'b0;
    #12;
    check("reset flags", {27'd0, ocupado, hecho, solicitud_bus, lectura, escritura}, 32'd0);
    check("reset direccion", direccion, 32'd0);
    check("reset dato_entrada", dato_entrada, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort with reset during the write of word 2 of 4.
    for (int k = 0; k < 4; k++) rexp[k] = mem[150 + k];
    h_seen = 0;
    @(posedge clk); #1;
    dir_origen    = 32'd150;
    dir_destino   = 32'd170;
    longitud      = 11'd4;
    inicio        = 1'b1;
    concesion_bus = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (hecho) h_seen++;
      @(posedge clk); #1;
    end
    check("abort escritura before reset", escritura, 1'b1);
    check("abort direccion before reset", direccion, 32'd172);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort flags after reset", {27'd0, ocupado, hecho, solicitud_bus, lectura, escritura},
          32'd0);
    check("abort direccion after reset", direccion, 32'd0);
    check("abort dato_entrada after reset", dato_entrada, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (hecho || ocupado) h_seen++;
    end
    check("abort no hecho", h_seen, 0);
    check("abort word0", mem[170], rexp[0]);
    check("abort word1", mem[171], rexp[1]);
    check("abort word2 unwritten", mem[172], 32'h5A00_00AC);
    check("abort word3 unwritten", mem[173], 32'h5A00_00AD);

    run_vec('{32'd150, 32'd180, 11'd2, 0, 0, 0, 8}, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
